// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register.
// Provides the MIPS ExcCode constants, the default reset and exception-entry PCs,
// the stage-word field widths and the packed header carried by every stage word.
package pipe_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned EXC_W   = 5;

    typedef logic [EXC_W-1:0] exccode_t;

    // MIPS CP0 Cause.ExcCode values
    localparam exccode_t EXC_NONE = 5'd0;
    localparam exccode_t EXC_MOD  = 5'd1;
    localparam exccode_t EXC_TLBL = 5'd2;
    localparam exccode_t EXC_TLBS = 5'd3;
    localparam exccode_t EXC_ADEL = 5'd4;
    localparam exccode_t EXC_ADES = 5'd5;
    localparam exccode_t EXC_IBE  = 5'd6;
    localparam exccode_t EXC_DBE  = 5'd7;
    localparam exccode_t EXC_SYS  = 5'd8;
    localparam exccode_t EXC_BP   = 5'd9;
    localparam exccode_t EXC_RI   = 5'd10;
    localparam exccode_t EXC_CPU  = 5'd11;
    localparam exccode_t EXC_OV   = 5'd12;
    localparam exccode_t EXC_TR   = 5'd13;

    localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [PC_W-1:0] DEF_EXC_PC   = 32'h0000_4180;

    // Fixed-width part of a stage word; payload channels travel alongside
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               isdelay;
        exccode_t           exccode;
    } stage_hdr_t;

    // Header of a bubble parked at the given PC
    function automatic stage_hdr_t bubble_hdr(input logic [PC_W-1:0] pc);
        stage_hdr_t h;
        h.pc      = pc;
        h.instr   = '0;
        h.isdelay = 1'b0;
        h.exccode = EXC_NONE;
        return h;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: upstream valid/ready + word in, downstream valid/ready + word out.
// master: the surrounding pipeline (drives in_* and out_ready).
// slave : the stage register (drives in_ready and out_*).
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DATA_W = 32
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [PC_W-1:0]         in_pc;
    logic [INSTR_W-1:0]      in_instr;
    logic [NCH*DATA_W-1:0]   in_data;
    logic                    in_isdelay;
    exccode_t                in_exccode;

    logic                    out_valid;
    logic                    out_ready;
    logic [PC_W-1:0]         out_pc;
    logic [INSTR_W-1:0]      out_instr;
    logic [NCH*DATA_W-1:0]   out_data;
    logic                    out_isdelay;
    exccode_t                out_exccode;

    modport master (
        output in_valid, in_pc, in_instr, in_data, in_isdelay, in_exccode, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_data, out_isdelay, out_exccode
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_data, in_isdelay, in_exccode, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_data, out_isdelay, out_exccode
    );

endinterface

// File: rtl/pipe_slot.sv
// One loadable stage-word entry (valid bit + header + payload).
// Ports: clk, reset (async active-low), flush_i (highest priority: empty and park at EXC_PC),
//        load_i (capture hdr_i/data_i, set valid), clear_i (drop valid, keep contents),
//        valid_o/hdr_o/data_o registered contents.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned      DW       = 128,
    parameter logic [PC_W-1:0]  RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0]  EXC_PC   = DEF_EXC_PC
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush_i,
    input  logic           load_i,
    input  logic           clear_i,
    input  stage_hdr_t     hdr_i,
    input  logic [DW-1:0]  data_i,
    output logic           valid_o,
    output stage_hdr_t     hdr_o,
    output logic [DW-1:0]  data_o
);

    logic           valid_q, valid_d;
    stage_hdr_t     hdr_q, hdr_d;
    logic [DW-1:0]  data_q, data_d;

    // Next-state: flush > load > clear > hold
    always_comb begin
        valid_d = valid_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            hdr_d   = bubble_hdr(EXC_PC);
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            hdr_d   = hdr_i;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            hdr_q   <= bubble_hdr(RESET_PC);
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign hdr_o   = hdr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready flow control, optional skid slot and exception flush.
// Ports: clk, reset (async active-low), flush (kills contents, parks bubble at EXC_PC),
//        bus (slave side of pipe_stage_reg_if: in_* upstream, out_* downstream).
// SKID=1: main + skid slot, in_ready is a register (!skid valid).
// SKID=0: main slot only, in_ready = !out_valid || out_ready (combinational).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      DATA_W   = 32,
    parameter logic [PC_W-1:0]  RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0]  EXC_PC   = DEF_EXC_PC,
    parameter bit               SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   bus
);

    localparam int unsigned DW = NCH * DATA_W;

    stage_hdr_t     in_hdr_c;
    stage_hdr_t     main_hdr, skid_hdr, main_hdr_d_c;
    logic [DW-1:0]  main_data, skid_data, main_data_d_c;
    logic           main_valid, skid_valid;
    logic           in_ready_c, accept_c, release_c;
    logic           main_load_c, main_clear_c, skid_load_c, skid_clear_c;

    assign in_hdr_c.pc      = bus.in_pc;
    assign in_hdr_c.instr   = bus.in_instr;
    assign in_hdr_c.isdelay = bus.in_isdelay;
    assign in_hdr_c.exccode = bus.in_exccode;

    // Slot selection: skid refills main on release; new words go to main when it frees up, else skid
    always_comb begin
        accept_c      = bus.in_valid && in_ready_c;
        release_c     = main_valid && bus.out_ready;
        main_load_c   = 1'b0;
        main_clear_c  = release_c;
        skid_load_c   = 1'b0;
        skid_clear_c  = release_c;
        main_hdr_d_c  = in_hdr_c;
        main_data_d_c = bus.in_data;
        if (release_c && skid_valid) begin
            // in_ready is low while skid is valid, so no accept can race this
            main_load_c   = 1'b1;
            main_hdr_d_c  = skid_hdr;
            main_data_d_c = skid_data;
        end else if (accept_c && (!main_valid || release_c)) begin
            main_load_c   = 1'b1;
        end else if (accept_c) begin
            skid_load_c   = 1'b1;
        end
    end

    pipe_slot #(
        .DW       (DW),
        .RESET_PC (RESET_PC),
        .EXC_PC   (EXC_PC)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .load_i  (main_load_c),
        .clear_i (main_clear_c),
        .hdr_i   (main_hdr_d_c),
        .data_i  (main_data_d_c),
        .valid_o (main_valid),
        .hdr_o   (main_hdr),
        .data_o  (main_data)
    );

    if (SKID) begin : g_skid
        pipe_slot #(
            .DW       (DW),
            .RESET_PC (RESET_PC),
            .EXC_PC   (EXC_PC)
        ) u_skid (
            .clk     (clk),
            .reset   (reset),
            .flush_i (flush),
            .load_i  (skid_load_c),
            .clear_i (skid_clear_c),
            .hdr_i   (in_hdr_c),
            .data_i  (bus.in_data),
            .valid_o (skid_valid),
            .hdr_o   (skid_hdr),
            .data_o  (skid_data)
        );
        assign in_ready_c = !skid_valid;
    end else begin : g_noskid
        assign skid_valid = 1'b0;
        assign skid_hdr   = bubble_hdr(RESET_PC);
        assign skid_data  = '0;
        assign in_ready_c = !main_valid || bus.out_ready;
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = main_valid;
    assign bus.out_pc      = main_hdr.pc;
    assign bus.out_instr   = main_hdr.instr;
    assign bus.out_data    = main_data;
    assign bus.out_isdelay = main_hdr.isdelay;
    assign bus.out_exccode = main_hdr.exccode;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance (a) and one SKID=0 instance (b).
module tb_pipe_stage_reg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush_a, flush_b;

    int vectors     = 0;
    int miscompares = 0;

    pipe_stage_reg_if #(.NCH(NCH), .DATA_W(DATA_W)) a_if ();
    pipe_stage_reg_if #(.NCH(NCH), .DATA_W(DATA_W)) b_if ();

    pipe_stage_reg #(.NCH(NCH), .DATA_W(DATA_W), .SKID(1'b1)) u_a (
        .clk   (clk),
        .reset (reset),
        .flush (flush_a),
        .bus   (a_if.slave)
    );

    pipe_stage_reg #(.NCH(NCH), .DATA_W(DATA_W), .SKID(1'b0)) u_b (
        .clk   (clk),
        .reset (reset),
        .flush (flush_b),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH*DATA_W-1:0] mk_data(input logic [31:0] pc);
        logic [NCH*DATA_W-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*DATA_W +: DATA_W] = pc + 32'(k);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] pc);
        a_if.in_pc      = pc;
        a_if.in_instr   = ~pc;
        a_if.in_data    = mk_data(pc);
        a_if.in_isdelay = 1'b0;
        a_if.in_exccode = 5'd0;
    endtask

    task automatic drive_b(input logic [31:0] pc);
        b_if.in_pc      = pc;
        b_if.in_instr   = ~pc;
        b_if.in_data    = mk_data(pc);
        b_if.in_isdelay = 1'b0;
        b_if.in_exccode = 5'd0;
    endtask

    // Full check of a valid word on instance a's outputs
    task automatic chk_word_a(input string tag, input logic [31:0] pc);
        logic [NCH*DATA_W-1:0] d;
        d = a_if.out_data;
        chk({tag, "_valid"}, 32'(a_if.out_valid), 32'd1);
        chk({tag, "_pc"},    a_if.out_pc, pc);
        chk({tag, "_instr"}, a_if.out_instr, ~pc);
        chk({tag, "_d0"},    d[0 +: 32], pc);
        chk({tag, "_d3"},    d[3*DATA_W +: 32], pc + 32'd3);
    endtask

    initial begin
        logic [NCH*DATA_W-1:0] d;
        reset   = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; drive_a(32'h0);
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; drive_b(32'h0);

        // Reset asserted mid-cycle takes effect immediately
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rst_pc",      a_if.out_pc, 32'h0000_3000);
        chk("rst_valid",   32'(a_if.out_valid), 32'd0);
        chk("rst_exc",     32'(a_if.out_exccode), 32'd0);
        chk("rst_instr",   a_if.out_instr, 32'd0);
        chk("rst_b_pc",    b_if.out_pc, 32'h0000_3000);
        tick();
        #2 reset = 1'b1;
        tick();
        chk("rst_ready",   32'(a_if.in_ready), 32'd1);

        // Streaming, one word per cycle
        a_if.out_ready = 1'b1;
        a_if.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_a(32'h3000 + 32'(4 * i));
            tick();
            chk_word_a("stream", 32'h3000 + 32'(4 * i));
            chk("stream_rdy", 32'(a_if.in_ready), 32'd1);
        end

        // Backpressure: exactly one extra word lands in the skid slot
        a_if.out_ready = 1'b0;
        drive_a(32'h3010);
        tick();
        chk("bp_hold_pc",  a_if.out_pc, 32'h300C);
        chk("bp_rdy0",     32'(a_if.in_ready), 32'd0);
        drive_a(32'h3014);
        tick();
        chk("bp_full_pc",  a_if.out_pc, 32'h300C);
        chk("bp_full_rdy", 32'(a_if.in_ready), 32'd0);
        a_if.out_ready = 1'b1;
        tick();
        chk_word_a("bp_skid", 32'h3010);
        chk("bp_rdy1",     32'(a_if.in_ready), 32'd1);
        tick();
        chk_word_a("bp_next", 32'h3014);
        a_if.in_valid = 1'b0;
        tick();
        chk("bp_drain_v",  32'(a_if.out_valid), 32'd0);
        chk("bp_bubble_pc", a_if.out_pc, 32'h3014);

        // Flush while full discards both slots and the concurrent input
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        drive_a(32'h3100);
        tick();
        drive_a(32'h3104);
        tick();
        chk("fl_full_rdy", 32'(a_if.in_ready), 32'd0);
        chk("fl_full_pc",  a_if.out_pc, 32'h3100);
        drive_a(32'h3108);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        a_if.in_valid = 1'b0;
        d = a_if.out_data;
        chk("fl_valid",    32'(a_if.out_valid), 32'd0);
        chk("fl_pc",       a_if.out_pc, 32'h0000_4180);
        chk("fl_instr",    a_if.out_instr, 32'd0);
        chk("fl_d0",       d[0 +: 32], 32'd0);
        chk("fl_exc",      32'(a_if.out_exccode), 32'd0);
        chk("fl_rdy",      32'(a_if.in_ready), 32'd1);
        a_if.out_ready = 1'b1;
        tick();
        chk("fl_skid_empty", 32'(a_if.out_valid), 32'd0);
        chk("fl_pc_stable",  a_if.out_pc, 32'h0000_4180);

        // Exception code and delay-slot flag pass through unchanged
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        drive_a(32'h3200);
        a_if.in_exccode = 5'd12;
        a_if.in_isdelay = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        chk("exc_code",    32'(a_if.out_exccode), 32'd12);
        chk("exc_delay",   32'(a_if.out_isdelay), 32'd1);
        chk_word_a("exc", 32'h3200);

        // Reset mid-transfer wipes the held word at once
        #2 reset = 1'b0;
        #1;
        chk("rmid_valid",  32'(a_if.out_valid), 32'd0);
        chk("rmid_pc",     a_if.out_pc, 32'h0000_3000);
        chk("rmid_exc",    32'(a_if.out_exccode), 32'd0);
        chk("rmid_delay",  32'(a_if.out_isdelay), 32'd0);
        tick();
        #2 reset = 1'b1;
        tick();
        chk("rmid_rdy",    32'(a_if.in_ready), 32'd1);
        chk("rmid_v2",     32'(a_if.out_valid), 32'd0);

        // SKID=0: combinational ready and same-cycle accept/release
        b_if.in_valid = 1'b1;
        drive_b(32'h3300);
        #1;
        chk("b_rdy_empty", 32'(b_if.in_ready), 32'd1);
        tick();
        chk("b_pc0",       b_if.out_pc, 32'h3300);
        chk("b_v0",        32'(b_if.out_valid), 32'd1);
        chk("b_rdy_bp",    32'(b_if.in_ready), 32'd0);
        b_if.out_ready = 1'b1;
        #1;
        chk("b_rdy_comb",  32'(b_if.in_ready), 32'd1);
        drive_b(32'h3304);
        tick();
        chk("b_pc1",       b_if.out_pc, 32'h3304);
        drive_b(32'h3308);
        tick();
        chk("b_pc2",       b_if.out_pc, 32'h3308);
        chk("b_v2",        32'(b_if.out_valid), 32'd1);
        b_if.out_ready = 1'b0;
        drive_b(32'h330C);
        tick();
        chk("b_hold_pc",   b_if.out_pc, 32'h3308);
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b1;
        tick();
        chk("b_drain_v",   32'(b_if.out_valid), 32'd0);
        chk("b_drain_pc",  b_if.out_pc, 32'h3308);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
